// File: rtl/hi_fanout_tree_if.sv
// Beat input bus and load outputs of hi_fanout_tree.
// par_err exists only when HI_FANOUT_TREE_PARITY_EN is defined.
interface hi_fanout_tree_if #(
  parameter int WIDTH     = 1,
  parameter int NUM_LOADS = 70
);
  localparam int IDXW = $clog2(NUM_LOADS);

  logic [WIDTH-1:0]           in_d;
  logic                       in_valid;
  logic                       in_mode;
  logic                       clear;
  logic [NUM_LOADS*WIDTH-1:0] q;
  logic [NUM_LOADS-1:0]       q_valid;
  logic [IDXW-1:0]            idx;
`ifdef HI_FANOUT_TREE_PARITY_EN
  logic                       par_err;

  modport master (output in_d, in_valid, in_mode, clear, input q, q_valid, idx, par_err);
  modport slave  (input in_d, in_valid, in_mode, clear, output q, q_valid, idx, par_err);
`else
  modport master (output in_d, in_valid, in_mode, clear, input q, q_valid, idx);
  modport slave  (input in_d, in_valid, in_mode, clear, output q, q_valid, idx);
`endif
endinterface

// File: rtl/hi_fanout_tree.sv
// Bounded-fanout register tree broadcasting/scattering beats to NUM_LOADS loads; parity option HI_FANOUT_TREE_PARITY_EN.
// Latency LEVELS+1 cycles, one beat per cycle, no backpressure: every valid beat is accepted.
module hi_fanout_tree #(
  parameter int WIDTH      = 1,
  parameter int NUM_LOADS  = 70,
  parameter int MAX_FANOUT = 8
) (
  input  logic            clk1,
  input  logic            rst_n,
  hi_fanout_tree_if.slave bus
);
  function automatic int calc_levels(input int n, input int f);
    int l;
    int p;
    l = 1;
    p = f;
    while (p < n) begin
      p = p * f;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LEVELS = calc_levels(NUM_LOADS, MAX_FANOUT);
  localparam int IDXW   = $clog2(NUM_LOADS);

  // Stage LEVELS has ceil(NUM_LOADS/MAX_FANOUT) nodes so every node, leaf row included, feeds at most MAX_FANOUT sinks.
  function automatic int stage_nodes(input int k, input int levels);
    int div;
    if (k == 0) return 1;
    div = 1;
    for (int s = 0; s <= levels - k; s++) div = div * MAX_FANOUT;
    return (NUM_LOADS + div - 1) / div;
  endfunction

  function automatic int node_off(input int k, input int levels);
    int sum;
    sum = 0;
    for (int s = 0; s < k; s++) sum = sum + stage_nodes(s, levels);
    return sum;
  endfunction

  localparam int TOTAL    = node_off(LEVELS + 1, LEVELS);
  localparam int LEAF_OFF = node_off(LEVELS, LEVELS);

  typedef struct packed {
    logic             vld;
    logic             mode;
    logic [IDXW-1:0]  tgt;
    logic [WIDTH-1:0] d;
`ifdef HI_FANOUT_TREE_PARITY_EN
    logic             par;
`endif
  } beat_t;

  beat_t                      drv_nxt;
  beat_t                      nd [TOTAL];
  logic [IDXW-1:0]            idx_r;
  logic [NUM_LOADS*WIDTH-1:0] q_r;
  logic [NUM_LOADS-1:0]       qv_r;
  logic [NUM_LOADS-1:0]       hit;

  // The beat carries the pre-increment index, so the next beat sees the advanced one.
  always_comb begin
    drv_nxt      = '0;
    drv_nxt.vld  = bus.in_valid;
    drv_nxt.mode = bus.in_mode;
    drv_nxt.tgt  = idx_r;
    drv_nxt.d    = bus.in_d;
`ifdef HI_FANOUT_TREE_PARITY_EN
    drv_nxt.par  = ^{bus.in_mode, idx_r, bus.in_d};
`endif
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)         nd[0] <= '0;
    else if (bus.clear) nd[0] <= '0;
    else                nd[0] <= drv_nxt;
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    for (genvar j = 0; j < stage_nodes(k, LEVELS); j++) begin : g_node
      localparam int SELF = node_off(k, LEVELS) + j;
      localparam int SRC  = node_off(k - 1, LEVELS) + j / MAX_FANOUT;
      always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)         nd[SELF] <= '0;
        else if (bus.clear) nd[SELF] <= '0;
        else                nd[SELF] <= nd[SRC];
      end
    end
  end

`ifdef HI_FANOUT_TREE_PARITY_EN
  logic [NUM_LOADS-1:0] perr;
  logic                 perr_r;
`endif

  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_load
    localparam int SRC = LEAF_OFF + i / MAX_FANOUT;
    assign hit[i] = nd[SRC].vld & (~nd[SRC].mode | (nd[SRC].tgt == IDXW'(i)));
`ifdef HI_FANOUT_TREE_PARITY_EN
    assign perr[i] = hit[i] & (^{nd[SRC].mode, nd[SRC].tgt, nd[SRC].d, nd[SRC].par});
`endif
    always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)         q_r[i*WIDTH +: WIDTH] <= '0;
      else if (bus.clear) q_r[i*WIDTH +: WIDTH] <= '0;
      else if (hit[i])    q_r[i*WIDTH +: WIDTH] <= nd[SRC].d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)         qv_r <= '0;
    else if (bus.clear) qv_r <= '0;
    else                qv_r <= hit;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)                          idx_r <= '0;
    else if (bus.clear)                  idx_r <= '0;
    else if (bus.in_valid & bus.in_mode) idx_r <= (idx_r == IDXW'(NUM_LOADS - 1)) ? '0 : idx_r + 1'b1;
  end

`ifdef HI_FANOUT_TREE_PARITY_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)         perr_r <= 1'b0;
    else if (bus.clear) perr_r <= 1'b0;
    else if (|perr)     perr_r <= 1'b1;
  end

  assign bus.par_err = perr_r;
`endif

  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
  assign bus.idx     = idx_r;
endmodule

// File: tb/tb_hi_fanout_tree.sv
// Bench for hi_fanout_tree: 70-load/8-fanout byte instance against a delay-line model, plus a 9-load/3-fanout instance.
module tb_hi_fanout_tree;
  localparam int NA   = 70;
  localparam int WA   = 8;
  localparam int LATA = 4;
  localparam int NB   = 9;

  typedef logic [NA*WA-1:0] cw_t;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  hi_fanout_tree_if #(.WIDTH(WA), .NUM_LOADS(NA)) bus_a ();
  hi_fanout_tree_if #(.WIDTH(1),  .NUM_LOADS(NB)) bus_b ();

  hi_fanout_tree #(.WIDTH(WA), .NUM_LOADS(NA), .MAX_FANOUT(8)) dut_a (.clk1(clk1), .rst_n(rst_n), .bus(bus_a));
  hi_fanout_tree #(.WIDTH(1),  .NUM_LOADS(NB), .MAX_FANOUT(3)) dut_b (.clk1(clk1), .rst_n(rst_n), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input cw_t act, input cw_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a beat reaches the loads LATA edges after it is accepted.
  typedef struct { bit v; bit m; int t; logic [WA-1:0] d; } mb_t;
  mb_t             pipe [$];
  logic [WA-1:0]   mq [NA];
  logic [NA-1:0]   mqv;
  int              midx;

  task automatic model_reset();
    mb_t z;
    z = '{v: 1'b0, m: 1'b0, t: 0, d: '0};
    pipe.delete();
    for (int i = 0; i < LATA; i++) pipe.push_back(z);
    for (int i = 0; i < NA; i++) mq[i] = '0;
    mqv  = '0;
    midx = 0;
  endtask

  task automatic model_edge(input bit v, input bit m, input bit c, input logic [WA-1:0] d);
    mb_t o;
    mb_t nb;
    if (c) begin
      model_reset();
      return;
    end
    o   = pipe.pop_front();
    mqv = '0;
    if (o.v)
      for (int i = 0; i < NA; i++)
        if (!o.m || o.t == i) begin
          mq[i]  = o.d;
          mqv[i] = 1'b1;
        end
    nb = '{v: v, m: m, t: midx, d: d};
    pipe.push_back(nb);
    if (v && m) midx = (midx + 1) % NA;
  endtask

  task automatic step(input bit v, input bit m, input bit c, input logic [WA-1:0] d);
    cw_t eq;
    bus_a.in_valid = v;
    bus_a.in_mode  = m;
    bus_a.clear    = c;
    bus_a.in_d     = d;
    @(posedge clk1);
    model_edge(v, m, c, d);
    @(negedge clk1);
    for (int i = 0; i < NA; i++) eq[i*WA +: WA] = mq[i];
    chk("model_q",   bus_a.q, eq);
    chk("model_qv",  cw_t'(bus_a.q_valid), cw_t'(mqv));
    chk("model_idx", cw_t'(bus_a.idx), cw_t'(midx));
    bus_a.in_valid = 1'b0;
    bus_a.in_mode  = 1'b0;
    bus_a.clear    = 1'b0;
    bus_a.in_d     = '0;
  endtask

  typedef struct {
    bit            v;
    bit            m;
    bit            c;
    logic [7:0]    d;
    int            e_idx;
    logic [NA-1:0] e_qv;
    logic [7:0]    e0;
    logic [7:0]    e1;
    logic [7:0]    e2;
  } vec_t;
  vec_t tbl [15];

  initial begin
    logic [NA-1:0] all1;
    all1 = '1;
    // Mixed modes, then a clear racing a beat with two beats in flight.
    tbl[0]  = '{1, 1, 0, 8'hA5, 1, '0,       8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1, 0, 0, 8'h3C, 1, '0,       8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1, 1, 0, 8'h11, 2, '0,       8'h00, 8'h00, 8'h00};
    tbl[3]  = '{0, 0, 0, 8'h00, 2, '0,       8'h00, 8'h00, 8'h00};
    tbl[4]  = '{0, 0, 0, 8'h00, 2, NA'(1),   8'hA5, 8'h00, 8'h00};
    tbl[5]  = '{0, 0, 0, 8'h00, 2, all1,     8'h3C, 8'h3C, 8'h3C};
    tbl[6]  = '{0, 0, 0, 8'h00, 2, NA'(2),   8'h3C, 8'h11, 8'h3C};
    tbl[7]  = '{0, 0, 0, 8'h00, 2, '0,       8'h3C, 8'h11, 8'h3C};
    tbl[8]  = '{1, 0, 0, 8'h55, 2, '0,       8'h3C, 8'h11, 8'h3C};
    tbl[9]  = '{1, 1, 0, 8'h66, 3, '0,       8'h3C, 8'h11, 8'h3C};
    tbl[10] = '{1, 0, 1, 8'h77, 0, '0,       8'h00, 8'h00, 8'h00};
    for (int r = 11; r < 15; r++) tbl[r] = '{0, 0, 0, 8'h00, 0, '0, 8'h00, 8'h00, 8'h00};

    bus_a.in_valid = 1'b0; bus_a.in_mode = 1'b0; bus_a.clear = 1'b0; bus_a.in_d = '0;
    bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0; bus_b.clear = 1'b0; bus_b.in_d = '0;
    model_reset();
    #3;
    chk("rst_q",   bus_a.q, '0);
    chk("rst_qv",  cw_t'(bus_a.q_valid), '0);
    chk("rst_idx", cw_t'(bus_a.idx), '0);
    @(negedge clk1);
    rst_n = 1'b1;

    // Small tree: broadcast latency of 3 and index wrap at 9.
    chk("b_rst_q", cw_t'(bus_b.q), '0);
    bus_b.in_valid = 1'b1; bus_b.in_mode = 1'b0; bus_b.in_d = 1'b1;
    @(negedge clk1);
    bus_b.in_valid = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      chk($sformatf("b_bc_qv%0d", c), cw_t'(bus_b.q_valid), (c == 3) ? cw_t'(9'h1FF) : '0);
      if (c == 3) chk("b_bc_q", cw_t'(bus_b.q), cw_t'(9'h1FF));
      @(negedge clk1);
    end
    bus_b.in_valid = 1'b1; bus_b.in_mode = 1'b1; bus_b.in_d = 1'b0;
    repeat (10) @(negedge clk1);
    bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0;
    chk("b_wrap_idx", cw_t'(bus_b.idx), cw_t'(1));
    repeat (4) @(negedge clk1);
    chk("b_scatter_q", cw_t'(bus_b.q), '0);
`ifdef HI_FANOUT_TREE_PARITY_EN
    chk("b_par_idle", cw_t'(bus_b.par_err), '0);
    bus_b.in_valid = 1'b1; bus_b.in_mode = 1'b0; bus_b.in_d = 1'b1;
    @(posedge clk1);
    #1;
    force dut_b.nd[1] = 8'h82;
    bus_b.in_valid = 1'b0;
    @(posedge clk1);
    #1;
    release dut_b.nd[1];
    repeat (4) @(negedge clk1);
    chk("b_par_set", cw_t'(bus_b.par_err), cw_t'(1));
    repeat (3) @(negedge clk1);
    chk("b_par_sticky", cw_t'(bus_b.par_err), cw_t'(1));
    bus_b.clear = 1'b1;
    @(negedge clk1);
    bus_b.clear = 1'b0;
    chk("b_par_clear", cw_t'(bus_b.par_err), '0);
`endif

    // Table-driven mixed-mode and clear-race sequence.
    step(0, 0, 1, 8'h00);
    for (int r = 0; r < 15; r++) begin
      step(tbl[r].v, tbl[r].m, tbl[r].c, tbl[r].d);
      chk($sformatf("tbl%0d_idx", r), cw_t'(bus_a.idx), cw_t'(tbl[r].e_idx));
      chk($sformatf("tbl%0d_qv", r),  cw_t'(bus_a.q_valid), cw_t'(tbl[r].e_qv));
      chk($sformatf("tbl%0d_q0", r),  cw_t'(bus_a.q[7:0]),   cw_t'(tbl[r].e0));
      chk($sformatf("tbl%0d_q1", r),  cw_t'(bus_a.q[15:8]),  cw_t'(tbl[r].e1));
      chk($sformatf("tbl%0d_q2", r),  cw_t'(bus_a.q[23:16]), cw_t'(tbl[r].e2));
    end

    // 72 back-to-back scatter beats wrap onto loads 0 and 1.
    for (int i = 0; i < 72; i++) step(1, 1, 0, 8'(i % 2));
    repeat (LATA) step(0, 0, 0, 8'h00);
    chk("wrap_idx", cw_t'(bus_a.idx), cw_t'(2));
    chk("wrap_q0",  cw_t'(bus_a.q[7:0]), '0);
    chk("wrap_q1",  cw_t'(bus_a.q[15:8]), cw_t'(1));
    chk("wrap_q69", cw_t'(bus_a.q[69*8 +: 8]), cw_t'(1));

    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 29) == 0, 8'($urandom));

    // Asynchronous reset between edges with three beats in the tree.
    step(1, 0, 0, 8'hFF);
    step(1, 1, 0, 8'h12);
    step(1, 0, 0, 8'h34);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q",   bus_a.q, '0);
    chk("arst_qv",  cw_t'(bus_a.q_valid), '0);
    chk("arst_idx", cw_t'(bus_a.idx), '0);
    @(negedge clk1);
    rst_n = 1'b1;
    model_reset();
    repeat (6) step(0, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
